// File: rtl/i2c_slave_ctrl_if.sv
// i2c_slave_ctrl_if: pin and byte-side bundle of the I2C slave sequencer.
//   scl_i / sda_i      raw (asynchronous) bus levels seen by the slave
//   tx_sda_i           serial bit from the external byte transmitter
//   sda_drive_low_o    open-drain SDA pull-down request
//   tx_en_o            transmitter enable (low holds it in reset)
//   scl_neg_edge_o     one-clk pulse per synchronised SCL falling edge
//   reg_addr_o         register pointer / register-file address
//   wr_data_o          last written data byte
//   wr_strobe_o        one-clk write pulse for wr_data_o at reg_addr_o
//   busy_o             sequencer is not idle
// The slave modport is used by the controller; master is the bus/environment side.
interface i2c_slave_ctrl_if;
  logic       scl_i;
  logic       sda_i;
  logic       tx_sda_i;
  logic       sda_drive_low_o;
  logic       tx_en_o;
  logic       scl_neg_edge_o;
  logic [7:0] reg_addr_o;
  logic [7:0] wr_data_o;
  logic       wr_strobe_o;
  logic       busy_o;

  modport slave (
    input  scl_i, sda_i, tx_sda_i,
    output sda_drive_low_o, tx_en_o, scl_neg_edge_o,
           reg_addr_o, wr_data_o, wr_strobe_o, busy_o
  );

  modport master (
    output scl_i, sda_i, tx_sda_i,
    input  sda_drive_low_o, tx_en_o, scl_neg_edge_o,
           reg_addr_o, wr_data_o, wr_strobe_o, busy_o
  );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: byte-level I2C slave sequencer.
//   clk_i      system clock, all logic on posedge
//   reset_n_i  asynchronous active-low reset
//   bus        i2c_slave_ctrl_if.slave (raw SCL/SDA in, SDA pull-down,
//              byte-transmitter enable, register pointer and write port)
// Synchronises SCL/SDA, detects START/STOP and SCL edges, matches the
// 7-bit address, ACKs address and write bytes, and hands read bits to an
// external transmitter. The first write byte after a START loads the
// register pointer; later bytes are data and post-increment it.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  i2c_slave_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK
  } state_t;

  state_t     state, state_nxt;

  // synchronisers: s1 -> s (synced) -> d (history)
  logic       scl_s1, scl_s, scl_d;
  logic       sda_s1, sda_s, sda_d;

  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       first_byte;   // next write byte is the pointer byte
  logic       data_byte;    // byte just ACKed in WR_ACK was data
  logic       rw;
  logic       rd_nack;
  logic       ack_drv;
  logic       tx_en;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic       scl_neg;

  logic       scl_rise, scl_fall, start, stop;
  logic       byte_done, addr_hit;

  assign scl_rise  = ~scl_d & scl_s;
  assign scl_fall  = scl_d & ~scl_s;
  assign start     = sda_d & ~sda_s & scl_s;
  assign stop      = ~sda_d & sda_s & scl_s;
  assign byte_done = scl_fall && (bit_cnt == 4'd8);
  assign addr_hit  = (shreg[7:1] == SLAVE_ADDR);

  // Sync flops reset high (idle bus level) so leaving reset on an idle bus
  // produces no spurious edges or START/STOP.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      scl_s1 <= 1'b1; scl_s <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= bus.scl_i; scl_s <= scl_s1; scl_d <= scl_s;
      sda_s1 <= bus.sda_i; sda_s <= sda_s1; sda_d <= sda_s;
    end
  end

  // state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_nxt;
  end

  // next-state logic; START/STOP override any SCL edge
  always_comb begin
    state_nxt = state;
    if (start)     state_nxt = ADDR;
    else if (stop) state_nxt = IDLE;
    else begin
      case (state)
        ADDR:     if (byte_done) state_nxt = addr_hit ? ADDR_ACK : IDLE;
        ADDR_ACK: if (scl_fall)  state_nxt = rw ? RD_BYTE : WR_BYTE;
        WR_BYTE:  if (byte_done) state_nxt = WR_ACK;
        WR_ACK:   if (scl_fall)  state_nxt = WR_BYTE;
        RD_BYTE:  if (scl_fall && bit_cnt == 4'd7) state_nxt = RD_ACK;
        RD_ACK:   if (scl_fall)  state_nxt = rd_nack ? IDLE : RD_BYTE;
        default:  ;
      endcase
    end
  end

  // datapath and registered outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      first_byte <= 1'b1;
      data_byte  <= 1'b0;
      rw         <= 1'b0;
      rd_nack    <= 1'b0;
      ack_drv    <= 1'b0;
      tx_en      <= 1'b0;
      reg_addr   <= 8'h00;
      wr_data    <= 8'h00;
      wr_strobe  <= 1'b0;
      scl_neg    <= 1'b0;
    end else begin
      scl_neg   <= scl_fall;
      wr_strobe <= 1'b0;
      if (start) begin
        bit_cnt    <= 4'd0;
        ack_drv    <= 1'b0;
        tx_en      <= 1'b0;
        first_byte <= 1'b1;
      end else if (stop) begin
        ack_drv <= 1'b0;
        tx_en   <= 1'b0;
      end else begin
        // a partial byte is simply abandoned by START/STOP above
        if (scl_rise && (state == ADDR || state == WR_BYTE) && bit_cnt != 4'd8) begin
          shreg   <= {shreg[6:0], sda_s};
          bit_cnt <= bit_cnt + 4'd1;
        end
        case (state)
          ADDR: if (byte_done && addr_hit) begin
            ack_drv <= 1'b1;
            rw      <= shreg[0];
          end
          ADDR_ACK: if (scl_fall) begin
            ack_drv <= 1'b0;
            bit_cnt <= 4'd0;
            tx_en   <= rw;
          end
          WR_BYTE: if (byte_done) begin
            ack_drv <= 1'b1;
            if (first_byte) begin
              reg_addr   <= shreg;
              first_byte <= 1'b0;
              data_byte  <= 1'b0;
            end else begin
              // pointer moves only after the ACK slot, so it is stable
              // while the strobe is high
              wr_data   <= shreg;
              wr_strobe <= 1'b1;
              data_byte <= 1'b1;
            end
          end
          WR_ACK: if (scl_fall) begin
            ack_drv <= 1'b0;
            bit_cnt <= 4'd0;
            if (data_byte) reg_addr <= reg_addr + 8'd1;
          end
          RD_BYTE: if (scl_fall) begin
            if (bit_cnt == 4'd7) begin
              tx_en   <= 1'b0;
              bit_cnt <= 4'd0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          RD_ACK: begin
            if (scl_rise) rd_nack <= sda_s;
            if (scl_fall) begin
              reg_addr <= reg_addr + 8'd1;
              tx_en    <= ~rd_nack;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // outputs; read data bits pass straight from the transmitter, gated by
  // the registered enable so reset releases SDA immediately
  always_comb begin
    bus.sda_drive_low_o = (state == RD_BYTE) ? (tx_en & ~bus.tx_sda_i) : ack_drv;
    bus.tx_en_o         = tx_en;
    bus.scl_neg_edge_o  = scl_neg;
    bus.reg_addr_o      = reg_addr;
    bus.wr_data_o       = wr_data;
    bus.wr_strobe_o     = wr_strobe;
    bus.busy_o          = (state != IDLE);
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl: bus-master stimulus for i2c_slave_ctrl with a
// transaction-level pointer model; expected register writes are queued
// and matched by a monitor on wr_strobe_o.
module tb_i2c_slave_ctrl;
  localparam int Q = 8;  // clocks per quarter SCL period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_slave_ctrl_if bus();

  logic m_sda  = 1'b1;
  logic scl    = 1'b1;
  logic tx_sda = 1'b1;

  // open-drain wired-AND of master and slave
  assign bus.scl_i    = scl;
  assign bus.sda_i    = m_sda & ~bus.sda_drive_low_o;
  assign bus.tx_sda_i = tx_sda;

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h50)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int tx_en_rises = 0;
  int neg_cnt = 0;
  int exp_falls = 0;
  bit drv_seen = 1'b0;
  logic [7:0] m_ptr = 8'h00;
  logic [7:0] wbuf [8];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard / monitor
  initial begin
    wr_t e;
    logic tx_en_q;
    tx_en_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.wr_strobe_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: addr %0h data %0h", bus.reg_addr_o, bus.wr_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_addr", bus.reg_addr_o, e.a);
          chk("strobe_data", bus.wr_data_o, e.d);
        end
      end
      if (bus.sda_drive_low_o) drv_seen = 1'b1;
      if (bus.tx_en_o && !tx_en_q) tx_en_rises++;
      if (bus.scl_neg_edge_o) neg_cnt++;
      tx_en_q = bus.tx_en_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic q();
    repeat (Q) @(posedge clk);
  endtask

  task automatic scl_lo();
    if (scl) exp_falls++;
    scl = 1'b0;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; q(); scl = 1'b1; q(); m_sda = 1'b0; q(); scl_lo(); q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; q(); scl = 1'b1; q(); m_sda = 1'b1; q();
  endtask

  task automatic send_bit(logic b);
    m_sda = b; q(); scl = 1'b1; q(); q(); scl_lo(); q();
  endtask

  task automatic send_byte(logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; q(); scl = 1'b1; q();
    @(negedge clk); acked = ~bus.sda_i;
    q(); scl_lo(); q();
  endtask

  task automatic recv_byte(logic [7:0] tx, logic nack, output logic [7:0] got);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; tx_sda = tx[i]; q(); scl = 1'b1; q();
      @(negedge clk); got[i] = bus.sda_i;
      q(); scl_lo(); q();
    end
    m_sda = nack; q(); scl = 1'b1; q(); q(); scl_lo(); q(); m_sda = 1'b1;
  endtask

  // START + address/W + n bytes from wbuf; model: first byte is the
  // pointer, each later byte is a write at the pointer then pointer+1
  task automatic wr_xfer(logic [6:0] a, int n);
    logic ack;
    logic hit;
    wr_t e;
    hit = (a == 7'h50);
    bus_start();
    chk("busy_after_start", bus.busy_o, 1);
    send_byte({a, 1'b0}, ack);
    chk("addr_ack", ack, hit);
    for (int i = 0; i < n; i++) begin
      if (hit) begin
        if (i == 0) m_ptr = wbuf[0];
        else begin
          e.a = m_ptr; e.d = wbuf[i];
          exp_q.push_back(e);
          m_ptr = m_ptr + 8'd1;
        end
      end
      send_byte(wbuf[i], ack);
      chk("data_ack", ack, hit);
    end
  endtask

  // START + 0x50/R + n bytes read from the current pointer, NACK on last
  task automatic rd_xfer(int n);
    logic ack;
    logic [7:0] tx, got;
    bus_start();
    send_byte({7'h50, 1'b1}, ack);
    chk("rd_addr_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      tx = 8'($urandom);
      recv_byte(tx, (i == n - 1), got);
      chk("rd_data", got, tx);
      m_ptr = m_ptr + 8'd1;
    end
  endtask

  initial begin
    logic ack;
    logic [7:0] got;
    int r0, f0, kind, n;
    logic [6:0] a;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sda_drive", bus.sda_drive_low_o, 0);
    chk("rst_tx_en", bus.tx_en_o, 0);
    chk("rst_reg_addr", bus.reg_addr_o, 0);
    chk("rst_wr_data", bus.wr_data_o, 0);
    chk("rst_strobe", bus.wr_strobe_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_neg_edge", bus.scl_neg_edge_o, 0);
    rst_n = 1'b1;
    q();

    // basic write: pointer 0x10, data A5, 3C
    wbuf[0] = 8'h10; wbuf[1] = 8'hA5; wbuf[2] = 8'h3C;
    wr_xfer(7'h50, 3);
    chk("busy_before_stop", bus.busy_o, 1);
    bus_stop(); q();
    chk("wr_final_ptr", bus.reg_addr_o, m_ptr);
    chk("wr_final_ptr_abs", bus.reg_addr_o, 8'h12);
    chk("busy_after_stop", bus.busy_o, 0);

    // wrong address: never drives SDA, no strobe, pointer kept
    drv_seen = 1'b0; f0 = exp_falls; neg_cnt = 0;
    wbuf[0] = 8'h10; wbuf[1] = 8'h55;
    wr_xfer(7'h51, 2);
    bus_stop(); q();
    chk("miss_no_drive", drv_seen, 0);
    chk("miss_idle", bus.busy_o, 0);
    chk("miss_ptr", bus.reg_addr_o, 8'h12);
    chk("scl_neg_edge_count", neg_cnt, exp_falls - f0);

    // pointer write then repeated START read of two bytes
    wbuf[0] = 8'h20;
    wr_xfer(7'h50, 1);
    r0 = tx_en_rises;
    bus_start();
    send_byte({7'h50, 1'b1}, ack);
    chk("rs_addr_ack", ack, 1);
    recv_byte(8'hC3, 1'b0, got);
    chk("rs_rd_byte1", got, 8'hC3);
    chk("rs_ptr1", bus.reg_addr_o, 8'h21);
    recv_byte(8'h5A, 1'b1, got);
    chk("rs_rd_byte2", got, 8'h5A);
    chk("rs_ptr2", bus.reg_addr_o, 8'h22);
    chk("rs_idle_after_nack", bus.busy_o, 0);
    chk("rs_tx_en_twice", tx_en_rises - r0, 2);
    m_ptr = 8'h22;
    bus_stop(); q();

    // pointer wrap
    wbuf[0] = 8'hFF; wbuf[1] = 8'h77;
    wr_xfer(7'h50, 2);
    bus_stop(); q();
    chk("wrap_ptr", bus.reg_addr_o, 8'h00);

    // STOP after half a data byte
    wbuf[0] = 8'h30;
    wr_xfer(7'h50, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    bus_stop(); q();
    chk("partial_ptr", bus.reg_addr_o, 8'h30);
    chk("partial_busy", bus.busy_o, 0);

    // randomized transfers against the pointer model
    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
      if (kind == 0) wr_xfer(7'h50, n);
      else if (kind == 1) begin
        a = 7'($urandom);
        if (a == 7'h50) a = 7'h2A;
        wr_xfer(a, n);
      end else rd_xfer(n);
      bus_stop(); q();
      chk("rand_ptr", bus.reg_addr_o, m_ptr);
      chk("rand_idle", bus.busy_o, 0);
    end

    // asynchronous reset while the address ACK is being driven
    wbuf[0] = 8'h9C;
    wr_xfer(7'h50, 1);
    bus_stop(); q();
    chk("pre_reset_ptr", bus.reg_addr_o, 8'h9C);
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'hA0 >> i) & 8'h01) != 0);
    m_sda = 1'b1;
    @(negedge clk);
    chk("ack_before_reset", bus.sda_drive_low_o, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sda", bus.sda_drive_low_o, 0);
    chk("async_rst_tx_en", bus.tx_en_o, 0);
    chk("async_rst_ptr", bus.reg_addr_o, 8'h00);
    scl = 1'b1; m_sda = 1'b1;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    m_ptr = 8'h00;
    q();

    // working again after reset
    wbuf[0] = 8'h05; wbuf[1] = 8'h11;
    wr_xfer(7'h50, 2);
    bus_stop(); q();
    chk("post_reset_ptr", bus.reg_addr_o, 8'h06);
    q();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
- Byte-level I2C slave sequencer that drives an external byte transmitter and a register file.
- Synchronises raw SCL/SDA and detects START, STOP and SCL edges.
- Matches the 7-bit slave address, generates ACKs and shifts in write bytes.
- Enables the byte transmitter for reads and manages an auto-incrementing register pointer.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit I2C address this slave responds to

Ports:
clk_i  input  1  system clock; all logic on posedge
reset_n_i  input  1  asynchronous, active-low reset
scl_i  input  1  raw SCL pin level (asynchronous)
sda_i  input  1  raw SDA pin level (asynchronous)
sda_drive_low_o  output  1  1 = pull SDA low (open drain); 0 = release
tx_en_o  output  1  enable to byte transmitter; low holds transmitter in reset
tx_sda_i  input  1  serial bit from byte transmitter, MSB first
scl_neg_edge_o  output  1  one-clk pulse per synchronised SCL falling edge
reg_addr_o  output  8  register pointer; also the read address into the register file
wr_data_o  output  8  last written data byte
wr_strobe_o  output  1  one-clk pulse; write wr_data_o to reg_addr_o
busy_o  output  1  1 when state != IDLE

Behaviour:
- Reset (async, reset_n_i=0): all outputs 0, state IDLE, pointer 8'h00, bit counter 0, first-byte flag set.
- Sync: 2-flop synchronisers on scl_i and sda_i, plus one history flop each.
- scl_rise = prev 0 / now 1; scl_fall = prev 1 / now 0.
- START = SDA high->low while synced SCL high. STOP = SDA low->high while synced SCL high.
- scl_neg_edge_o = scl_fall, registered, independent of state.
- START in any state (including repeated START):
  - Go to ADDR; clear bit counter; release SDA; tx_en_o=0.
  - Pointer is kept; first-byte flag is set.
- STOP in any state: go to IDLE; release SDA; tx_en_o=0. START/STOP take priority over SCL edges in the same cycle.
- IDLE: wait for START.
- ADDR:
  - Shift synced SDA MSB-first on each scl_rise; 8 bits.
  - On the scl_fall after bit 8: if byte[7:1]==SLAVE_ADDR, set sda_drive_low_o=1 and go to ADDR_ACK.
  - Otherwise go to IDLE (bus ignored until the next START).
- ADDR_ACK: on the next scl_fall, release SDA.
  - R/W=1: go to RD_BYTE; assert tx_en_o in the same cycle.
  - R/W=0: go to WR_BYTE.
- WR_BYTE:
  - Shift 8 bits on scl_rise.
  - On the scl_fall after bit 8, set sda_drive_low_o=1 and go to WR_ACK.
  - If first-byte flag: reg_addr_o <= byte; clear flag.
  - Else: wr_data_o <= byte and pulse wr_strobe_o for one clk, with reg_addr_o unchanged during the pulse.
- WR_ACK: on the next scl_fall, release SDA.
  - Increment reg_addr_o only if this byte was a data byte.
  - Go to WR_BYTE.
- RD_BYTE:
  - sda_drive_low_o = tx_en_o & ~tx_sda_i, combinational from registered state.
  - Count scl_fall; on the 8th, set tx_en_o=0, release SDA and go to RD_ACK.
- RD_ACK: sample SDA on scl_rise.
  - 0 (ACK): on the following scl_fall, increment reg_addr_o, go to RD_BYTE and re-assert tx_en_o (new byte).
  - 1 (NACK): on the following scl_fall, increment reg_addr_o and go to IDLE.
- Pointer arithmetic: 8-bit modulo, 8'hFF+1 -> 8'h00.
- Partial byte ended by START/STOP: discarded; no strobe; pointer unchanged.
- SDA is only ever driven low during an ACK slot or a read data bit of 0. It is never driven in IDLE or ADDR.

Test Plan:
- Write 0x50/W, 0x10, 0xA5, 0x3C, STOP:
  - ACK low on 4 slots.
  - wr_strobe_o pulses with (addr 0x10, data 0xA5) then (0x11, 0x3C).
  - Final reg_addr_o=0x12; busy_o falls on STOP.
- Address 0x51/W:
  - sda_drive_low_o stays 0 for the whole transfer.
  - No wr_strobe_o; state returns to IDLE.
- Write 0x50/W, 0x20, repeated START, 0x50/R; master ACKs byte 1, NACKs byte 2:
  - tx_en_o asserts twice; SDA tracks tx_sda_i.
  - reg_addr_o goes 0x20 -> 0x21 -> 0x22; IDLE after NACK.
- Pointer 0xFF, write one data byte 0x77:
  - Strobe at addr 0xFF; reg_addr_o wraps to 0x00.
- STOP after 4 bits of a data byte:
  - No wr_strobe_o; reg_addr_o unchanged; busy_o=0.
- reset_n_i low during ADDR_ACK:
  - sda_drive_low_o and tx_en_o go to 0 asynchronously, before the next clk edge.
  - reg_addr_o=0x00.
